// File: rtl/gaussian_sample_arbiter.sv
// gaussian_sample_arbiter
// Shares one free-running gaussian sample source among NUM_REQ consumers.
// After a warm-up window the block grants requesters round-robin and streams
// one fresh source sample per load into a single registered output slot.
// The source is never back-pressured: samples that arrive while the slot is
// stalled are simply dropped, so every delivered sample is used at most once.
module gaussian_sample_arbiter #(
  parameter int OUT_WIDTH     = 16,
  parameter int NUM_REQ       = 4,
  parameter int LEN_WIDTH     = 8,
  parameter int WARMUP_CYCLES = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [OUT_WIDTH-1:0]           src_random,
  input  logic                           src_valid,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]   req_len,
  input  logic [NUM_REQ-1:0]             out_ready,
  output logic [NUM_REQ-1:0]             grant,
  output logic [OUT_WIDTH-1:0]           out_data,
  output logic                           out_valid,
  output logic                           out_last,
  output logic                           warm
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES + 1) : 1;
  localparam bit NO_WARMUP = (WARMUP_CYCLES == 0);
  // Count value at which the final discarded sample is being consumed.
  localparam logic [CNT_W-1:0] WARM_LAST =
    (WARMUP_CYCLES > 0) ? CNT_W'(WARMUP_CYCLES - 1) : '0;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W:0]   NREQ_EXT = (IDX_W + 1)'(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    IDLE   = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t               state_reg;
  logic [CNT_W-1:0]     warm_cnt_reg;
  logic [IDX_W-1:0]     rr_ptr_reg;
  logic [IDX_W-1:0]     gidx_reg;
  logic [LEN_WIDTH-1:0] remaining_reg;

  // Per-requester burst-length fields and the request vector rotated so that
  // candidate 0 is the requester at rr_ptr, candidate 1 the next one, etc.
  logic [LEN_WIDTH-1:0] len_field [NUM_REQ];
  logic [IDX_W:0]       cand_sum  [NUM_REQ];
  logic [IDX_W-1:0]     cand_idx  [NUM_REQ];
  logic [NUM_REQ-1:0]   cand_req;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      assign len_field[gi] = req_len[gi*LEN_WIDTH +: LEN_WIDTH];
      assign cand_sum[gi]  = {1'b0, rr_ptr_reg} + (IDX_W + 1)'(gi);
      assign cand_idx[gi]  = (cand_sum[gi] >= NREQ_EXT)
                             ? IDX_W'(cand_sum[gi] - NREQ_EXT)
                             : IDX_W'(cand_sum[gi]);
      assign cand_req[gi]  = req[cand_idx[gi]];
    end
  endgenerate

  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;
  logic [LEN_WIDTH-1:0] pick_len;
  logic [LEN_WIDTH-1:0] pick_len_eff;

  // Round-robin pick: lowest rotated candidate wins (scan downward so the
  // last assignment is the closest requester at or after rr_ptr).
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (cand_req[i]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx[i];
      end
    end
  end

  // A zero-length request still gets one sample.
  assign pick_len     = len_field[pick_idx];
  assign pick_len_eff = (pick_len == '0) ? LEN_WIDTH'(1) : pick_len;

  logic           ready_g;
  logic           xfer;
  logic           load;
  logic [IDX_W-1:0] rr_next;

  assign ready_g = out_ready[gidx_reg];
  assign xfer    = out_valid && ready_g;
  // The slot accepts a new sample only when it is empty or draining this cycle.
  assign load    = src_valid && (remaining_reg != '0) && (!out_valid || ready_g);
  assign rr_next = (gidx_reg == LAST_IDX) ? '0 : gidx_reg + 1'b1;

  // Control FSM with registered grant and output slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= WARMUP;
      warm_cnt_reg  <= '0;
      rr_ptr_reg    <= '0;
      gidx_reg      <= '0;
      remaining_reg <= '0;
      grant         <= '0;
      out_data      <= '0;
      out_valid     <= 1'b0;
      out_last      <= 1'b0;
      warm          <= 1'b0;
    end else begin
      case (state_reg)
        WARMUP: begin
          if (NO_WARMUP || (src_valid && warm_cnt_reg == WARM_LAST)) begin
            state_reg <= IDLE;
            warm      <= 1'b1;
          end else if (src_valid) begin
            warm_cnt_reg <= warm_cnt_reg + 1'b1;
          end
        end
        IDLE: begin
          if (pick_valid) begin
            gidx_reg      <= pick_idx;
            remaining_reg <= pick_len_eff;
            grant         <= ONE_HOT0 << pick_idx;
            state_reg     <= STREAM;
          end
        end
        STREAM: begin
          if (xfer && out_last) begin
            grant      <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            rr_ptr_reg <= rr_next;
            state_reg  <= IDLE;
          end else if (load) begin
            out_data      <= src_random;
            out_valid     <= 1'b1;
            out_last      <= (remaining_reg == LEN_WIDTH'(1));
            remaining_reg <= remaining_reg - 1'b1;
          end else if (xfer) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          state_reg <= WARMUP;
        end
      endcase
    end
  end

endmodule
